sc_row_marker_driver: RTL and testbench

//  Transmit side of the bottom-row position check: drives the 8-bit row bus that the

---
 rtl/sc_row_marker_driver.sv | 124 ++++++++++++
 tb/tb_sc_row_marker_driver.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sc_row_marker_driver.sv
//==============================================================================
// Module   : sc_row_marker_driver
// Brief    : One-hot row marker that walks toward a fixed target index on command.
// Revision : 1.0
//==============================================================================
`default_nettype none

module sc_row_marker_driver #(
    parameter int DATAWIDTH    = 8,
    parameter int TARGET_INDEX = 4,
    parameter int STEP_DIV     = 4
) (
    input  logic                 ROWDRIVER_CLOCK_50,
    input  logic                 ROWDRIVER_RESET_InLow,
    input  logic                 ROWDRIVER_load_InHigh,
    input  logic [DATAWIDTH-1:0] ROWDRIVER_data_InBUS,
    input  logic                 ROWDRIVER_go_InHigh,
    input  logic                 ROWDRIVER_abort_InHigh,
    output logic [DATAWIDTH-1:0] ROWDRIVER_data_OutBUS,
    output logic                 ROWDRIVER_busy_OutHigh,
    output logic                 ROWDRIVER_done_OutHigh,
    output logic                 ROWDRIVER_error_OutHigh
);

    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [DATAWIDTH-1:0] c_ONE      = DATAWIDTH'(1);
    localparam logic [DATAWIDTH-1:0] c_TARGET   = c_ONE << TARGET_INDEX;
    localparam logic [DIV_W-1:0]     c_DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [DIV_W-1:0]     c_DIV_ONE  = DIV_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOVE = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [DATAWIDTH-1:0] r_data;
    logic [DIV_W-1:0]     r_div;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_error;

    logic                 w_in_onehot;
    logic [DATAWIDTH-1:0] w_shifted;

    // x & (x-1) clears the lowest set bit, so a nonzero x with nothing left is one-hot
    assign w_in_onehot = (ROWDRIVER_data_InBUS != '0) &&
                         ((ROWDRIVER_data_InBUS & (ROWDRIVER_data_InBUS - c_ONE)) == '0);

    // For a one-hot marker, numeric order equals bit-index order
    assign w_shifted = (r_data < c_TARGET) ? (r_data << 1) : (r_data >> 1);

    always_ff @(posedge ROWDRIVER_CLOCK_50 or negedge ROWDRIVER_RESET_InLow) begin
        if (!ROWDRIVER_RESET_InLow) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_div   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (ROWDRIVER_load_InHigh) begin
                        if (w_in_onehot) begin
                            r_data  <= ROWDRIVER_data_InBUS;
                            r_error <= 1'b0;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end else if (ROWDRIVER_go_InHigh) begin
                        if (r_data == '0) begin
                            r_error <= 1'b1;
                        end else if (r_data == c_TARGET) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_MOVE;
                            r_busy  <= 1'b1;
                            r_div   <= '0;
                        end
                    end
                end
                S_MOVE: begin
                    if (ROWDRIVER_abort_InHigh) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_div   <= '0;
                    end else if (r_div == c_DIV_LAST) begin
                        r_div  <= '0;
                        r_data <= w_shifted;
                        if (w_shifted == c_TARGET) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_div <= r_div + c_DIV_ONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign ROWDRIVER_data_OutBUS   = r_data;
    assign ROWDRIVER_busy_OutHigh  = r_busy;
    assign ROWDRIVER_done_OutHigh  = r_done;
    assign ROWDRIVER_error_OutHigh = r_error;

endmodule

`default_nettype wire

// File: tb/tb_sc_row_marker_driver.sv
//==============================================================================
// Module   : tb_sc_row_marker_driver
// Brief    : Directed and randomized bench for sc_row_marker_driver.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_sc_row_marker_driver;

    localparam int DW = 8;
    localparam int TI = 4;
    localparam int SD = 4;

    logic          clk;
    logic          rst_n;
    logic          load;
    logic [DW-1:0] din;
    logic          go;
    logic          abort;
    logic [DW-1:0] dout;
    logic          busy;
    logic          done;
    logic          error;

    int tests_run = 0;
    int tests_failed = 0;

    sc_row_marker_driver #(
        .DATAWIDTH   (DW),
        .TARGET_INDEX(TI),
        .STEP_DIV    (SD)
    ) dut (
        .ROWDRIVER_CLOCK_50     (clk),
        .ROWDRIVER_RESET_InLow  (rst_n),
        .ROWDRIVER_load_InHigh  (load),
        .ROWDRIVER_data_InBUS   (din),
        .ROWDRIVER_go_InHigh    (go),
        .ROWDRIVER_abort_InHigh (abort),
        .ROWDRIVER_data_OutBUS  (dout),
        .ROWDRIVER_busy_OutHigh (busy),
        .ROWDRIVER_done_OutHigh (done),
        .ROWDRIVER_error_OutHigh(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] row_of(input int idx);
        logic [DW-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic do_load(input logic [DW-1:0] v);
        load = 1'b1;
        din  = v;
        tick();
        load = 1'b0;
    endtask

    // Walk a marker from index start toward TI; abort_edge=0 means no abort.
    // Marker position is derived from elapsed edges: one step every SD edges.
    task automatic run_case(input int start, input int abort_edge, input bit noise);
        int d, dir, total, shifts, k;
        bit aborted;
        do_load(row_of(start));
        check("load_data", dout, row_of(start));
        check("load_err", error, 0);
        d     = (TI > start) ? TI - start : start - TI;
        dir   = (TI > start) ? 1 : -1;
        total = d * SD;
        go = 1'b1;
        tick();
        go = 1'b0;
        if (d == 0) begin
            check("at_tgt_done", done, 1);
            check("at_tgt_busy", busy, 0);
            check("at_tgt_data", dout, row_of(TI));
            tick();
            check("at_tgt_done_end", done, 0);
            return;
        end
        check("go_busy", busy, 1);
        check("go_data", dout, row_of(start));
        aborted = 1'b0;
        for (k = 1; k <= total + 1 && !aborted; k++) begin
            abort = (k == abort_edge);
            if (noise) begin
                load = $urandom_range(0, 1);
                go   = $urandom_range(0, 1);
                din  = DW'($urandom);
            end
            tick();
            abort = 1'b0;
            load  = 1'b0;
            go    = 1'b0;
            if (k == abort_edge) begin
                aborted = 1'b1;
                shifts  = (k - 1) / SD;
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_data", dout, row_of(start + dir * shifts));
                tick();
                check("abort_no_done", done, 0);
            end else begin
                shifts = (k / SD < d) ? k / SD : d;
                check("move_data", dout, row_of(start + dir * shifts));
                check("move_busy", busy, (k < total) ? 1 : 0);
                check("move_done", done, (k == total) ? 1 : 0);
            end
        end
        check("end_err", error, 0);
    endtask

    initial begin
        int start, ab;
        rst_n = 1'b0;
        load  = 1'b0;
        din   = '0;
        go    = 1'b0;
        abort = 1'b0;
        #12;
        check("rst_data", dout, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", error, 0);
        rst_n = 1'b1;
        tick();

        // go with an empty row
        go = 1'b1;
        tick();
        go = 1'b0;
        check("go_empty_err", error, 1);
        check("go_empty_busy", busy, 0);
        tick();
        check("go_empty_busy2", busy, 0);

        do_load(8'h18);
        check("bad_load_err", error, 1);
        check("bad_load_data", dout, 0);
        do_load(8'h02);
        check("good_load_err", error, 0);
        check("good_load_data", dout, 8'h02);
        do_load(8'h00);
        check("zero_load_err", error, 1);
        check("zero_load_data", dout, 8'h02);

        // load wins over go; the go is dropped
        load = 1'b1;
        go   = 1'b1;
        din  = 8'h40;
        tick();
        load = 1'b0;
        go   = 1'b0;
        check("ld_go_data", dout, 8'h40);
        check("ld_go_busy", busy, 0);
        tick();
        check("ld_go_busy2", busy, 0);

        run_case(0, 0, 1'b0);
        run_case(7, 0, 1'b0);
        run_case(TI, 0, 1'b0);
        run_case(0, 6, 1'b0);
        run_case(0, 8, 1'b0);

        // asynchronous reset mid-move and mid-clock
        do_load(8'h01);
        go = 1'b1;
        tick();
        go = 1'b0;
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_data", dout, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_err", error, 0);
        repeat (2) tick();
        check("rst_hold_done", done, 0);
        rst_n = 1'b1;
        tick();

        // abort in IDLE is ignored
        do_load(8'h08);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_data", dout, 8'h08);

        for (int i = 0; i < 20; i++) begin
            start = $urandom_range(0, DW - 1);
            ab = 0;
            if (start != TI && $urandom_range(0, 2) == 0)
                ab = $urandom_range(1, ((start > TI) ? start - TI : TI - start) * SD);
            run_case(start, ab, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        tests_failed++;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
